// File: rtl/game_score_keeper.sv
// N-player lives/gold tracker with IDLE/PLAY/OVER game FSM, rising-edge event inputs.
// Latency: counters update one cycle after an input edge; game_over follows the deciding counter update by one more cycle.
// Backpressure: none; every input edge is consumed in the cycle it is seen (or deliberately ignored by state).
module game_score_keeper #(
    parameter  int NUM_PLAYERS = 2,
    parameter  int LIFE_W      = 2,
    parameter  int GOLD_W      = 3,
    parameter  int START_LIVES = 3,
    parameter  int MAX_LIVES   = 3,
    parameter  int GOLD_TO_WIN = 5,
    localparam int WIN_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          game_start_i,
    input  logic [NUM_PLAYERS-1:0]        death_i,
    input  logic [NUM_PLAYERS-1:0]        more_life_i,
    input  logic [NUM_PLAYERS-1:0]        more_gold_i,
    output logic [NUM_PLAYERS*LIFE_W-1:0] lives_o,
    output logic [NUM_PLAYERS*GOLD_W-1:0] gold_o,
    output logic [NUM_PLAYERS-1:0]        alive_o,
    output logic                          playing_o,
    output logic                          game_over_o,
    output logic [WIN_W-1:0]              winner_o,
    output logic                          winner_valid_o
);

    localparam logic [LIFE_W-1:0] START_L  = LIFE_W'(START_LIVES);
    localparam logic [LIFE_W-1:0] MAX_L    = LIFE_W'(MAX_LIVES);
    localparam logic [GOLD_W-1:0] GOLD_MAX = '1;
    localparam logic [GOLD_W-1:0] WIN_G    = GOLD_W'(GOLD_TO_WIN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [LIFE_W-1:0]        lives_q [NUM_PLAYERS];
    logic [LIFE_W-1:0]        lives_d [NUM_PLAYERS];
    logic [GOLD_W-1:0]        gold_q  [NUM_PLAYERS];
    logic [GOLD_W-1:0]        gold_d  [NUM_PLAYERS];
    logic [WIN_W-1:0]         winner_q, winner_d;
    logic                     winner_valid_q, winner_valid_d;

    logic                     start_prev_q;
    logic [NUM_PLAYERS-1:0]   death_prev_q, life_prev_q, gold_prev_q;

    logic                     start_ev;
    logic [NUM_PLAYERS-1:0]   death_ev, life_ev, gold_ev;

    logic                     gold_hit;
    logic [WIN_W-1:0]         gold_idx;
    logic [3:0]               alive_cnt;
    logic [WIN_W-1:0]         alive_idx;

    assign start_ev = game_start_i & ~start_prev_q;
    assign death_ev = death_i      & ~death_prev_q;
    assign life_ev  = more_life_i  & ~life_prev_q;
    assign gold_ev  = more_gold_i  & ~gold_prev_q;

    // Previous-value registers track the inputs every cycle, reset included, so a level
    // held high across reset release is already "seen" and does not produce an event.
    always_ff @(posedge clk_i) begin
        start_prev_q <= game_start_i;
        death_prev_q <= death_i;
        life_prev_q  <= more_life_i;
        gold_prev_q  <= more_gold_i;
    end

    // End-of-game inputs from the registered counters: lowest gold winner, live count, last live index.
    always_comb begin
        gold_hit  = 1'b0;
        gold_idx  = '0;
        alive_cnt = 4'd0;
        alive_idx = '0;
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (gold_q[p] == WIN_G) begin
                gold_hit = 1'b1;
                gold_idx = WIN_W'(p);
            end
            if (lives_q[p] != '0) begin
                alive_cnt = alive_cnt + 4'd1;
                alive_idx = WIN_W'(p);
            end
        end
    end

    // Next-state: game FSM, counter updates for live players, and winner latch on the way into OVER.
    always_comb begin
        state_d        = state_q;
        lives_d        = lives_q;
        gold_d         = gold_q;
        winner_d       = winner_q;
        winner_valid_d = winner_valid_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_ev) begin
                    state_d        = S_PLAY;
                    winner_d       = '0;
                    winner_valid_d = 1'b0;
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        lives_d[p] = START_L;
                        gold_d[p]  = '0;
                    end
                end
            end

            S_PLAY: begin
                if (start_ev) begin
                    // Restart in place: reload and discard any events of this cycle.
                    winner_d       = '0;
                    winner_valid_d = 1'b0;
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        lives_d[p] = START_L;
                        gold_d[p]  = '0;
                    end
                end else begin
                    // Dead players are frozen; simultaneous death and life cancel out.
                    for (int p = 0; p < NUM_PLAYERS; p++) begin
                        if (lives_q[p] != '0) begin
                            if (life_ev[p] && !death_ev[p] && (lives_q[p] < MAX_L)) begin
                                lives_d[p] = lives_q[p] + LIFE_W'(1);
                            end else if (death_ev[p] && !life_ev[p]) begin
                                lives_d[p] = lives_q[p] - LIFE_W'(1);
                            end
                            if (gold_ev[p] && (gold_q[p] != GOLD_MAX)) begin
                                gold_d[p] = gold_q[p] + GOLD_W'(1);
                            end
                        end
                    end

                    // Gold win beats last-survivor, which beats the all-dead draw.
                    if (gold_hit) begin
                        state_d        = S_OVER;
                        winner_d       = gold_idx;
                        winner_valid_d = 1'b1;
                    end else if ((NUM_PLAYERS > 1) && (alive_cnt == 4'd1)) begin
                        state_d        = S_OVER;
                        winner_d       = alive_idx;
                        winner_valid_d = 1'b1;
                    end else if (alive_cnt == 4'd0) begin
                        state_d        = S_OVER;
                        winner_d       = '0;
                        winner_valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset mid-game aborts to IDLE with cleared counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                lives_q[p] <= '0;
                gold_q[p]  <= '0;
            end
        end else begin
            state_q        <= state_d;
            winner_q       <= winner_d;
            winner_valid_q <= winner_valid_d;
            lives_q        <= lives_d;
            gold_q         <= gold_d;
        end
    end

    // Output packing; alive is only meaningful once a game has been started.
    always_comb begin
        lives_o = '0;
        gold_o  = '0;
        alive_o = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            lives_o[p*LIFE_W +: LIFE_W] = lives_q[p];
            gold_o[p*GOLD_W +: GOLD_W]  = gold_q[p];
            alive_o[p] = (state_q != S_IDLE) && (lives_q[p] != '0);
        end
    end

    assign playing_o      = (state_q == S_PLAY);
    assign game_over_o    = (state_q == S_OVER);
    assign winner_o       = winner_q;
    assign winner_valid_o = winner_valid_q;

endmodule

// File: tb/tb_game_score_keeper.sv
// Bench for game_score_keeper: directed per-cycle vector table, reset corner sequence, random run vs. model.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time unit after the next edge.
// Model tracks the game with plain integers and applies the game rules directly.
module tb_game_score_keeper;

    localparam int N   = 2;
    localparam int LW  = 2;
    localparam int GW  = 3;
    localparam int SL  = 3;
    localparam int ML  = 3;
    localparam int GTW = 5;
    localparam int GMAX = (1 << GW) - 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           game_start = 1'b0;
    logic [N-1:0]   death = '0, more_life = '0, more_gold = '0;
    logic [N*LW-1:0] lives;
    logic [N*GW-1:0] gold;
    logic [N-1:0]   alive;
    logic           playing, game_over, winner, winner_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_score_keeper #(
        .NUM_PLAYERS(N), .LIFE_W(LW), .GOLD_W(GW),
        .START_LIVES(SL), .MAX_LIVES(ML), .GOLD_TO_WIN(GTW)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .game_start_i   (game_start),
        .death_i        (death),
        .more_life_i    (more_life),
        .more_gold_i    (more_gold),
        .lives_o        (lives),
        .gold_o         (gold),
        .alive_o        (alive),
        .playing_o      (playing),
        .game_over_o    (game_over),
        .winner_o       (winner),
        .winner_valid_o (winner_valid)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic [1:0]  death;
        logic [1:0]  life;
        logic [1:0]  gold;
        logic [3:0]  exp_lives;
        logic [5:0]  exp_gold;
        logic [1:0]  exp_alive;
        logic        exp_play;
        logic        exp_over;
        logic        exp_win;
        logic        exp_wv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic s, input logic [1:0] d, input logic [1:0] l,
                                input logic [1:0] g, input logic [3:0] el, input logic [5:0] eg,
                                input logic [1:0] ea, input logic ep, input logic eo,
                                input logic ew, input logic ev);
        vec_t v;
        v.rst = r; v.start = s; v.death = d; v.life = l; v.gold = g;
        v.exp_lives = el; v.exp_gold = eg; v.exp_alive = ea;
        v.exp_play = ep; v.exp_over = eo; v.exp_win = ew; v.exp_wv = ev;
        return v;
    endfunction

    task automatic compare(input string name, input logic [3:0] el, input logic [5:0] eg,
                           input logic [1:0] ea, input logic ep, input logic eo,
                           input logic ew, input logic ev);
        checks++;
        if ({lives, gold, alive, playing, game_over, winner, winner_valid} !==
            {el, eg, ea, ep, eo, ew, ev}) begin
            errors++;
            $display("FAIL %s: got lives=%h gold=%h alive=%b play=%b over=%b win=%b wv=%b ; want lives=%h gold=%h alive=%b play=%b over=%b win=%b wv=%b",
                     name, lives, gold, alive, playing, game_over, winner, winner_valid,
                     el, eg, ea, ep, eo, ew, ev);
        end
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        reset = v.rst; game_start = v.start;
        death = v.death; more_life = v.life; more_gold = v.gold;
        @(posedge clk); #1;
        compare(name, v.exp_lives, v.exp_gold, v.exp_alive, v.exp_play, v.exp_over, v.exp_win, v.exp_wv);
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_PLAY = 1, M_OVER = 2;
    int       m_state;
    int       m_lives [N];
    int       m_gold  [N];
    int       m_win;
    bit       m_wv;
    bit       m_pstart;
    bit [N-1:0] m_pd, m_pl, m_pg;

    task automatic m_reload();
        for (int p = 0; p < N; p++) begin
            m_lives[p] = SL;
            m_gold[p]  = 0;
        end
        m_win = 0;
        m_wv  = 1'b0;
        m_state = M_PLAY;
    endtask

    task automatic model_step(input bit r, input bit s, input bit [N-1:0] d, input bit [N-1:0] l,
                              input bit [N-1:0] g);
        bit sev;
        int n_alive, last_alive, gold_winner, nl;
        sev = s && !m_pstart;
        if (r) begin
            m_state = M_IDLE;
            for (int p = 0; p < N; p++) begin
                m_lives[p] = 0;
                m_gold[p]  = 0;
            end
            m_win = 0;
            m_wv  = 1'b0;
        end else if (m_state == M_PLAY && !sev) begin
            gold_winner = -1;
            n_alive = 0;
            last_alive = 0;
            for (int p = 0; p < N; p++) begin
                if (m_gold[p] == GTW && gold_winner < 0) gold_winner = p;
                if (m_lives[p] > 0) begin
                    n_alive++;
                    last_alive = p;
                end
            end
            for (int p = 0; p < N; p++) begin
                if (m_lives[p] > 0) begin
                    nl = m_lives[p] + int'(l[p] && !m_pl[p]) - int'(d[p] && !m_pd[p]);
                    m_lives[p] = (nl < 0) ? 0 : (nl > ML) ? ML : nl;
                    if (g[p] && !m_pg[p] && m_gold[p] < GMAX) m_gold[p]++;
                end
            end
            if (gold_winner >= 0) begin
                m_state = M_OVER; m_win = gold_winner; m_wv = 1'b1;
            end else if (N > 1 && n_alive == 1) begin
                m_state = M_OVER; m_win = last_alive; m_wv = 1'b1;
            end else if (n_alive == 0) begin
                m_state = M_OVER; m_win = 0; m_wv = 1'b0;
            end
        end else if (sev) begin
            m_reload();
        end
        m_pstart = s; m_pd = d; m_pl = l; m_pg = g;
    endtask

    // ---------------- test ----------------
    bit          r_rst, r_st;
    bit [N-1:0]  r_d, r_l, r_g;
    logic [3:0]  e_l;
    logic [5:0]  e_g;
    logic [1:0]  e_a;

    initial begin
        // Reset, start, held-death single event, decrement to zero, survivor wins.
        tbl.push_back(mk(1, 0, 2'b00, 2'b00, 2'b00, 4'h0, 6'd0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 4'hF, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 2'b00, 2'b00, 4'hE, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 4'hE, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 4'hE, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 4'hE, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 4'hD, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b10, 2'b10, 2'b00, 4'hD, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 4'hD, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 2'b10, 2'b00, 4'hD, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b01, 2'b00, 2'b00, 4'hC, 6'd0, 2'b10, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 4'hC, 6'd0, 2'b10, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 2'b11, 2'b00, 2'b00, 4'hC, 6'd0, 2'b10, 0, 1, 1, 1));
        // Restart from OVER, then both players reach the gold target together.
        tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 4'hF, 6'd0, 2'b11, 1, 0, 0, 0));
        for (int k = 1; k <= 9; k++) begin
            tbl.push_back(mk(0, 1, 2'b00, 2'b00, (k % 2 == 1) ? 2'b11 : 2'b00,
                             4'hF, 6'(9 * ((k + 1) / 2)), 2'b11, 1, 0, 0, 0));
        end
        tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 4'hF, 6'd45, 2'b11, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 4'hF, 6'd45, 2'b11, 0, 1, 0, 1));
        // Restart, both die on the same edge -> draw, then restart again.
        tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 4'hF, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 2'b00, 2'b00, 4'hA, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 4'hA, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 2'b00, 2'b00, 4'h5, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 4'h5, 6'd0, 2'b11, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b11, 2'b00, 2'b00, 4'h0, 6'd0, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 4'h0, 6'd0, 2'b00, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 6'd0, 2'b00, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 2'b00, 2'b00, 4'hF, 6'd0, 2'b11, 1, 0, 0, 0));

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(tbl[i], $sformatf("row%0d", i));
        end

        // Reset mid-game with death (and start) held: no stale events after release.
        apply_vec(mk(0, 1, 2'b01, 2'b00, 2'b00, 4'hE, 6'd0, 2'b11, 1, 0, 0, 0), "rst_pre_hit");
        apply_vec(mk(1, 1, 2'b01, 2'b00, 2'b00, 4'h0, 6'd0, 2'b00, 0, 0, 0, 0), "rst_mid_play");
        apply_vec(mk(0, 1, 2'b01, 2'b00, 2'b00, 4'h0, 6'd0, 2'b00, 0, 0, 0, 0), "rst_release_held");
        apply_vec(mk(0, 0, 2'b01, 2'b00, 2'b00, 4'h0, 6'd0, 2'b00, 0, 0, 0, 0), "rst_idle_hold");
        apply_vec(mk(0, 1, 2'b01, 2'b00, 2'b00, 4'hF, 6'd0, 2'b11, 1, 0, 0, 0), "rst_restart");
        apply_vec(mk(0, 1, 2'b01, 2'b00, 2'b00, 4'hF, 6'd0, 2'b11, 1, 0, 0, 0), "rst_death_still_held");
        apply_vec(mk(0, 1, 2'b00, 2'b00, 2'b00, 4'hF, 6'd0, 2'b11, 1, 0, 0, 0), "rst_death_fall");
        apply_vec(mk(0, 1, 2'b01, 2'b00, 2'b00, 4'hE, 6'd0, 2'b11, 1, 0, 0, 0), "rst_death_rise");

        // Random levels checked every cycle against the model.
        r_st = 1'b0; r_d = '0; r_l = '0; r_g = '0;
        m_pstart = 1'b0; m_pd = '0; m_pl = '0; m_pg = '0;
        for (int i = 0; i < 3000; i++) begin
            r_rst = (i == 0) || ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) r_st = ~r_st;
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 5) == 0) r_d[p] = ~r_d[p];
                if ($urandom_range(0, 7) == 0) r_l[p] = ~r_l[p];
                if ($urandom_range(0, 3) == 0) r_g[p] = ~r_g[p];
            end
            reset = r_rst; game_start = r_st;
            death = r_d; more_life = r_l; more_gold = r_g;
            model_step(r_rst, r_st, r_d, r_l, r_g);
            e_l = '0; e_g = '0; e_a = '0;
            for (int p = 0; p < N; p++) begin
                e_l[p*LW +: LW] = LW'(m_lives[p]);
                e_g[p*GW +: GW] = GW'(m_gold[p]);
                e_a[p] = (m_state != M_IDLE) && (m_lives[p] > 0);
            end
            @(posedge clk); #1;
            compare($sformatf("rand%0d", i), e_l, e_g, e_a, m_state == M_PLAY, m_state == M_OVER,
                    1'(m_win), m_wv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
